// File: rtl/adder_stim_checker.sv
// Clocked stimulus/checker for a 1-bit full adder: sweeps all 8 input vectors, checks S/Cout, reports errors.
// Optional first-failure capture is built when the ERR_LOG_EN macro is defined.
module adder_stim_checker #(
  parameter int SETTLE_CYCLES = 2,
  parameter int NUM_PASSES    = 1,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             t1,
  output logic             t2,
  output logic             t3,
  input  logic             p1,
  input  logic             p2,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [2:0]       fail_vec,
  output logic             fail_vld,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int CNT_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int PCNT_W = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(NUM_PASSES - 1);

  state_t             state_q;
  logic [2:0]         vec_q;
  logic [2:0]         t_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [PCNT_W-1:0]  pcnt_q;
  logic [ERR_W-1:0]   err_cnt_q;
  logic [ERR_W-1:0]   err_cnt_d;
  logic               busy_q;
  logic               done_q;
  logic               pass_q;
  logic [1:0]         sum_exp;
  logic               mismatch;

`ifdef ERR_LOG_EN
  logic [2:0]         fail_vec_q;
  logic               fail_vld_q;
`endif

  // Arithmetic reference for the vector currently on t1/t2/t3.
  always_comb begin
    sum_exp   = {1'b0, vec_q[2]} + {1'b0, vec_q[1]} + {1'b0, vec_q[0]};
    mismatch  = ({p2, p1} != sum_exp);
    err_cnt_d = err_cnt_q;
    if (mismatch && (err_cnt_q != {ERR_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      vec_q     <= 3'd0;
      t_q       <= 3'd0;
      cnt_q     <= '0;
      pcnt_q    <= '0;
      err_cnt_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
`ifdef ERR_LOG_EN
      fail_vec_q <= 3'd0;
      fail_vld_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q   <= ST_SETTLE;
            vec_q     <= 3'd0;
            t_q       <= 3'd0;
            cnt_q     <= '0;
            pcnt_q    <= '0;
            err_cnt_q <= '0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
`ifdef ERR_LOG_EN
            fail_vec_q <= 3'd0;
            fail_vld_q <= 1'b0;
`endif
          end
        end
        ST_SETTLE: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_q <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          err_cnt_q <= err_cnt_d;
`ifdef ERR_LOG_EN
          // Only the first mismatch of a run is recorded.
          if (mismatch && !fail_vld_q) begin
            fail_vec_q <= vec_q;
            fail_vld_q <= 1'b1;
          end
`endif
          if (vec_q != 3'd7) begin
            vec_q   <= vec_q + 3'd1;
            t_q     <= vec_q + 3'd1;
            cnt_q   <= '0;
            state_q <= ST_SETTLE;
          end else if (pcnt_q != PCNT_LAST) begin
            pcnt_q  <= pcnt_q + PCNT_W'(1);
            vec_q   <= 3'd0;
            t_q     <= 3'd0;
            cnt_q   <= '0;
            state_q <= ST_SETTLE;
          end else begin
            state_q <= ST_DONE;
            t_q     <= 3'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_cnt_d == '0);
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign t1        = t_q[2];
  assign t2        = t_q[1];
  assign t3        = t_q[0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_cnt   = err_cnt_q;
  assign dbg_state = state_q;

`ifdef ERR_LOG_EN
  assign fail_vec = fail_vec_q;
  assign fail_vld = fail_vld_q;
`else
  assign fail_vec = 3'b000;
  assign fail_vld = 1'b0;
`endif

endmodule

// File: tb/tb_adder_stim_checker.sv
// Directed bench for adder_stim_checker: three instances (defaults, two passes, single settle cycle)
// each driven by a behavioural adder that can be faulted.
module tb_adder_stim_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // 0: correct adder, 1: Cout stuck at 0, 2: S inverted
  int mode0 = 0;
  int mode1 = 0;
  int mode2 = 0;

  function automatic logic [1:0] adder_model(input logic [2:0] v, input int mode);
    logic [1:0] s;
    s = {1'b0, v[2]} + {1'b0, v[1]} + {1'b0, v[0]};
    if (mode == 1) s[1] = 1'b0;
    if (mode == 2) s[0] = ~s[0];
    return s;
  endfunction

  // Instance 0: defaults
  logic       start0 = 1'b0;
  logic       t1_0, t2_0, t3_0, p1_0, p2_0, busy0, done0, pass0, fail_vld0;
  logic [7:0] err0;
  logic [2:0] fail_vec0, tv0;
  logic [1:0] st0;
  assign tv0 = {t1_0, t2_0, t3_0};
  assign {p2_0, p1_0} = adder_model(tv0, mode0);

  adder_stim_checker u0 (
    .clk(clk), .rst(rst), .start(start0),
    .t1(t1_0), .t2(t2_0), .t3(t3_0), .p1(p1_0), .p2(p2_0),
    .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0),
    .fail_vec(fail_vec0), .fail_vld(fail_vld0), .dbg_state(st0)
  );

  // Instance 1: two passes
  logic       start1 = 1'b0;
  logic       t1_1, t2_1, t3_1, p1_1, p2_1, busy1, done1, pass1, fail_vld1;
  logic [7:0] err1;
  logic [2:0] fail_vec1, tv1;
  logic [1:0] st1;
  assign tv1 = {t1_1, t2_1, t3_1};
  assign {p2_1, p1_1} = adder_model(tv1, mode1);

  adder_stim_checker #(.NUM_PASSES(2)) u1 (
    .clk(clk), .rst(rst), .start(start1),
    .t1(t1_1), .t2(t2_1), .t3(t3_1), .p1(p1_1), .p2(p2_1),
    .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1),
    .fail_vec(fail_vec1), .fail_vld(fail_vld1), .dbg_state(st1)
  );

  // Instance 2: single settle cycle
  logic       start2 = 1'b0;
  logic       t1_2, t2_2, t3_2, p1_2, p2_2, busy2, done2, pass2, fail_vld2;
  logic [7:0] err2;
  logic [2:0] fail_vec2, tv2;
  logic [1:0] st2;
  assign tv2 = {t1_2, t2_2, t3_2};
  assign {p2_2, p1_2} = adder_model(tv2, mode2);

  adder_stim_checker #(.SETTLE_CYCLES(1)) u2 (
    .clk(clk), .rst(rst), .start(start2),
    .t1(t1_2), .t2(t2_2), .t3(t3_2), .p1(p1_2), .p2(p2_2),
    .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2),
    .fail_vec(fail_vec2), .fail_vld(fail_vld2), .dbg_state(st2)
  );

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    step(2);
    check("rst_t", 32'(tv0), 0);
    check("rst_busy", 32'(busy0), 0);
    check("rst_done", 32'(done0), 0);
    check("rst_pass", 32'(pass0), 0);
    check("rst_err", 32'(err0), 0);
    check("rst_fail_vec", 32'(fail_vec0), 0);
    check("rst_fail_vld", 32'(fail_vld0), 0);
    check("rst_state", 32'(st0), 0);
    check("rst_done1", 32'(done1), 0);
    check("rst_done2", 32'(done2), 0);
    rst = 1'b0;
    step(1);

    // 1: correct adder, full sweep
    mode0 = 0;
    start0 = 1'b1;
    step(1);
    start0 = 1'b0;
    check("t1_busy_start", 32'(busy0), 1);
    check("t1_t_start", 32'(tv0), 0);
    for (int j = 1; j <= 23; j++) begin
      step(1);
      check("t1_sweep", 32'(tv0), 32'(j / 3));
      if (j == 23) check("t1_done_early", 32'(done0), 0);
    end
    step(1);
    check("t1_done", 32'(done0), 1);
    check("t1_pass", 32'(pass0), 1);
    check("t1_err", 32'(err0), 0);
    check("t1_busy_end", 32'(busy0), 0);
    check("t1_t_end", 32'(tv0), 0);
    check("t1_state", 32'(st0), 3);
    check("t1_fail_vld", 32'(fail_vld0), 0);

    // 2: Cout stuck at 0, restart from DONE
    mode0 = 1;
    start0 = 1'b1;
    step(1);
    start0 = 1'b0;
    check("t2_done_drop", 32'(done0), 0);
    step(12);
    check("t2_err_mid", 32'(err0), 1);
    step(12);
    check("t2_done", 32'(done0), 1);
    check("t2_err", 32'(err0), 4);
    check("t2_pass", 32'(pass0), 0);
`ifdef ERR_LOG_EN
    check("t2_fail_vec", 32'(fail_vec0), 3);
    check("t2_fail_vld", 32'(fail_vld0), 1);
`else
    check("t2_fail_vec", 32'(fail_vec0), 0);
    check("t2_fail_vld", 32'(fail_vld0), 0);
`endif

    // 3: two passes, Cout stuck at 0
    mode1 = 1;
    start1 = 1'b1;
    step(1);
    start1 = 1'b0;
    for (int j = 1; j <= 48; j++) begin
      step(1);
      if (j == 23) check("t3_t_last", 32'(tv1), 7);
      if (j == 24) begin
        check("t3_t_wrap", 32'(tv1), 0);
        check("t3_busy_wrap", 32'(busy1), 1);
      end
      if (j == 47) check("t3_done_early", 32'(done1), 0);
    end
    check("t3_done", 32'(done1), 1);
    check("t3_err", 32'(err1), 8);
    check("t3_pass", 32'(pass1), 0);
    check("t3_state", 32'(st1), 3);
`ifdef ERR_LOG_EN
    check("t3_fail_vec", 32'(fail_vec1), 3);
    check("t3_fail_vld", 32'(fail_vld1), 1);
`else
    check("t3_fail_vec", 32'(fail_vec1), 0);
    check("t3_fail_vld", 32'(fail_vld1), 0);
`endif

    // 4: start held high; u0 is in DONE with err_cnt=4
    start0 = 1'b1;
    step(1);
    check("t4_restart_err", 32'(err0), 0);
    check("t4_restart_busy", 32'(busy0), 1);
    check("t4_restart_fail_vld", 32'(fail_vld0), 0);
    step(12);
    check("t4_no_restart_t", 32'(tv0), 4);
    check("t4_no_restart_busy", 32'(busy0), 1);
    step(12);
    check("t4_done", 32'(done0), 1);
    check("t4_err", 32'(err0), 4);
    step(1);
    start0 = 1'b0;
    check("t4_redone_drop", 32'(done0), 0);
    check("t4_rebusy", 32'(busy0), 1);
    check("t4_reerr", 32'(err0), 0);
    check("t4_ret", 32'(tv0), 0);

    // 5: reset mid-run at vec 4 in SETTLE
    step(13);
    check("t5_pre_t", 32'(tv0), 4);
    check("t5_pre_err", 32'(err0), 1);
    check("t5_pre_state", 32'(st0), 1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("t5_t", 32'(tv0), 0);
    check("t5_busy", 32'(busy0), 0);
    check("t5_err", 32'(err0), 0);
    check("t5_fail_vld", 32'(fail_vld0), 0);
    check("t5_done", 32'(done0), 0);
    check("t5_state", 32'(st0), 0);

    // 6: single settle cycle, S inverted
    mode2 = 2;
    start2 = 1'b1;
    step(1);
    start2 = 1'b0;
    for (int j = 1; j <= 16; j++) begin
      step(1);
      if (j == 15) begin
        check("t6_done_early", 32'(done2), 0);
        check("t6_busy", 32'(busy2), 1);
      end
    end
    check("t6_done", 32'(done2), 1);
    check("t6_err", 32'(err2), 8);
    check("t6_pass", 32'(pass2), 0);
    check("t6_state", 32'(st2), 3);
`ifdef ERR_LOG_EN
    check("t6_fail_vec", 32'(fail_vec2), 0);
    check("t6_fail_vld", 32'(fail_vld2), 1);
`else
    check("t6_fail_vec", 32'(fail_vec2), 0);
    check("t6_fail_vld", 32'(fail_vld2), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
